mole_spawner: RTL and testbench

- Game-sequencing stage wrapped around the keypad hit detector.
- Upstream side: chooses pseudo-random mole cells on the 4x4 keypad grid and drives mole_row/mole_col into the keypad stage.
- Downstream side: consumes that stage's registered mole_is_hitted level, edge-qualifies it and keeps score and miss counts for the display logic.
- Runs a timed show/gap cycle while is_started is high.

---
 rtl/mole_spawner.sv | 173 +++++++++++++++++
 tb/tb_mole_spawner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - whack-a-mole sequencer: LFSR mole placement, show/gap timing, hit/miss scoring (optional MOLE_SPEEDUP_EN)
module mole_spawner #(
    parameter int          LIFE_CYCLES = 25000000,
    parameter int          GAP_CYCLES  = 5000000,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               is_started,
    input  logic               mole_is_hitted,
    output logic [1:0]         mole_row,
    output logic [1:0]         mole_col,
    output logic               mole_visible,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam int MAX_CYCLES = (LIFE_CYCLES > GAP_CYCLES) ? LIFE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BLANK_CYCLES = CNT_W'(2);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE    = SCORE_W'(1);
    localparam logic [15:0]        LFSR_TAPS    = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [CNT_W-1:0] cnt;
    logic             hit_q;
    logic             start_q;
    logic [3:0]       cand;
    logic             start_rise;
    logic             hit_rise;
    logic             hit_ok;
    logic             show_done;

    assign start_rise = is_started & ~start_q;
    assign hit_rise   = mole_is_hitted & ~hit_q;
    // The first two SHOW cycles still carry the keypad stage's view of the previous cell.
    assign hit_ok     = hit_rise & (cnt >= BLANK_CYCLES);
    assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

`ifdef MOLE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] LIFE_INIT  = CNT_W'(LIFE_CYCLES);
    localparam logic [CNT_W-1:0] LIFE_FLOOR = CNT_W'(LIFE_CYCLES / 4);

    logic [CNT_W-1:0] life;
    logic [CNT_W-1:0] life_dec;
    logic [CNT_W-1:0] life_next;

    always_comb begin
        life_dec  = life - (life >> 3);
        life_next = life;
        if (life > LIFE_FLOOR) begin
            life_next = (life_dec < LIFE_FLOOR) ? LIFE_FLOOR : life_dec;
        end
    end

    assign show_done = (cnt == life - CNT_ONE);
`else
    localparam logic [CNT_W-1:0] LIFE_LAST = CNT_W'(LIFE_CYCLES - 1);

    assign show_done = (cnt == LIFE_LAST);
`endif

    // Never redraw the cell that is currently shown.
    always_comb begin
        cand = lfsr[3:0];
        if (cand == {mole_row, mole_col}) begin
            cand = cand + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mole_row     <= 2'd0;
            mole_col     <= 2'd0;
            mole_visible <= 1'b0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            score        <= '0;
            misses       <= '0;
            lfsr         <= LFSR_SEED;
            cnt          <= '0;
            hit_q        <= 1'b0;
            start_q      <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
            life         <= LIFE_INIT;
`endif
        end else begin
            hit_q      <= mole_is_hitted;
            start_q    <= is_started;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (is_started) begin
                lfsr <= lfsr_next;
            end

            if (!is_started) begin
                state        <= IDLE;
                mole_visible <= 1'b0;
            end else if (start_rise) begin
                score        <= '0;
                misses       <= '0;
                cnt          <= '0;
                state        <= GAP;
                mole_visible <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
                life         <= LIFE_INIT;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        mole_visible <= 1'b0;
                    end
                    GAP: begin
                        if (cnt == GAP_LAST) begin
                            mole_row     <= cand[3:2];
                            mole_col     <= cand[1:0];
                            mole_visible <= 1'b1;
                            cnt          <= '0;
                            state        <= SHOW;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    SHOW: begin
                        if (hit_ok) begin
                            if (score != SCORE_MAX) begin
                                score <= score + SCORE_ONE;
                            end
                            hit_pulse    <= 1'b1;
                            mole_visible <= 1'b0;
                            cnt          <= '0;
                            state        <= GAP;
`ifdef MOLE_SPEEDUP_EN
                            life         <= life_next;
`endif
                        end else if (show_done) begin
                            if (misses != SCORE_MAX) begin
                                misses <= misses + SCORE_ONE;
                            end
                            miss_pulse   <= 1'b1;
                            mole_visible <= 1'b0;
                            cnt          <= '0;
                            state        <= GAP;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        mole_visible <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - directed and randomized checks of mole_spawner against a game-rule reference model
module tb_mole_spawner;

    localparam int LIFE      = 20;
    localparam int GAP       = 4;
    localparam int SW        = 4;
    localparam int SMAX      = (1 << SW) - 1;
    localparam int M_IDLE    = 0;
    localparam int M_GAP     = 1;
    localparam int M_SHOW    = 2;
    localparam int WAIT_MAX  = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          is_started;
    logic          mole_is_hitted;
    logic [1:0]    mole_row;
    logic [1:0]    mole_col;
    logic          mole_visible;
    logic [SW-1:0] score;
    logic [SW-1:0] misses;
    logic          hit_pulse;
    logic          miss_pulse;

    int tests = 0;
    int fails = 0;

    // Reference model: game phase, cycles spent in it, shown cell, tallies.
    int          m_mode;
    int          m_elapsed;
    int          m_cell;
    int          m_score;
    int          m_miss;
    int          m_life;
    bit          m_vis;
    bit          m_hitp;
    bit          m_missp;
    bit          m_prev_st;
    bit          m_prev_hit;
    logic [15:0] m_lfsr;

    mole_spawner #(
        .LIFE_CYCLES(LIFE),
        .GAP_CYCLES (GAP),
        .SCORE_W    (SW),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .is_started    (is_started),
        .mole_is_hitted(mole_is_hitted),
        .mole_row      (mole_row),
        .mole_col      (mole_col),
        .mole_visible  (mole_visible),
        .score         (score),
        .misses        (misses),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_elapsed = 0; m_cell = 0; m_score = 0; m_miss = 0;
        m_life = LIFE; m_vis = 0; m_hitp = 0; m_missp = 0;
        m_prev_st = 0; m_prev_hit = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_edge(input bit r, input bit st, input bit hit);
        bit rise;
        int cand;
        rise    = hit && !m_prev_hit;
        m_hitp  = 0;
        m_missp = 0;
        if (r) begin
            model_reset();
            return;
        end
        if (!st) begin
            m_mode = M_IDLE;
            m_vis  = 0;
        end else if (!m_prev_st) begin
            m_score = 0; m_miss = 0; m_elapsed = 0; m_mode = M_GAP; m_vis = 0; m_life = LIFE;
        end else if (m_mode == M_GAP) begin
            if (m_elapsed == GAP - 1) begin
                cand = int'(m_lfsr[3:0]);
                if (cand == m_cell) cand = (cand + 1) % 16;
                m_cell = cand; m_mode = M_SHOW; m_vis = 1; m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else if (m_mode == M_SHOW) begin
            if (rise && m_elapsed >= 2) begin
                if (m_score < SMAX) m_score++;
                m_hitp = 1; m_vis = 0; m_mode = M_GAP; m_elapsed = 0;
`ifdef MOLE_SPEEDUP_EN
                if (m_life > LIFE / 4) begin
                    m_life = m_life - m_life / 8;
                    if (m_life < LIFE / 4) m_life = LIFE / 4;
                end
`endif
            end else if (m_elapsed == m_life - 1) begin
                if (m_miss < SMAX) m_miss++;
                m_missp = 1; m_vis = 0; m_mode = M_GAP; m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        if (st) m_lfsr = lfsr_step(m_lfsr);
        m_prev_st  = st;
        m_prev_hit = hit;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst, is_started, mole_is_hitted);
        #1;
        check("visible", mole_visible, m_vis);
        check("row", mole_row, m_cell / 4);
        check("col", mole_col, m_cell % 4);
        check("score", score, m_score);
        check("misses", misses, m_miss);
        check("hit_pulse", hit_pulse, m_hitp);
        check("miss_pulse", miss_pulse, m_missp);
    endtask

    // Advance until the upcoming cycle is in the given phase (el < 0: any elapsed count).
    task automatic wait_until(input int mode, input int el);
        int n = 0;
        while (!(m_mode == mode && (el < 0 || m_elapsed == el)) && n < WAIT_MAX) begin
            tick();
            n++;
        end
        check("wait_bound", n < WAIT_MAX, 1);
    endtask

    initial begin
        int n;
        int s0;
        int s1;
        logic [3:0] prev_cell;

        model_reset();
        rst = 1'b1; is_started = 1'b0; mole_is_hitted = 1'b0;
        tick(); tick();
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);
        check("rst_visible", mole_visible, 0);
        rst = 1'b0;
        tick();

        // Start: first mole appears on the fifth edge after is_started rises.
        is_started = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!mole_visible && n < 20);
        check("start_latency", n, 5);

        // Clean hit on SHOW cycle 5, next mole 4 cycles later on another cell.
        wait_until(M_SHOW, 4);
        prev_cell = {mole_row, mole_col};
        mole_is_hitted = 1'b1; tick(); mole_is_hitted = 1'b0;
        check("clean_hit_pulse", hit_pulse, 1);
        check("clean_hit_score", score, 1);
        check("clean_hit_hidden", mole_visible, 0);
        n = 0;
        do begin tick(); n++; end while (!mole_visible && n < 20);
        check("respawn_latency", n, 4);
        check("respawn_new_cell", {mole_row, mole_col} != prev_cell, 1);

        // Key held across spawn scores nothing; release and re-press on cycle 8 does.
        wait_until(M_GAP, -1);
        s0 = m_score;
        mole_is_hitted = 1'b1;
        wait_until(M_SHOW, 6);
        check("held_no_score", score, s0);
        mole_is_hitted = 1'b0; tick();
        mole_is_hitted = 1'b1; tick();
        mole_is_hitted = 1'b0;
        check("repress_pulse", hit_pulse, 1);
        check("repress_score", score, s0 + 1);

        // Rises on SHOW cycles 1 and 2 are blanked; cycle 3 is the first accepted.
        s0 = m_score;
        wait_until(M_SHOW, 0);
        mole_is_hitted = 1'b1; tick(); tick(); mole_is_hitted = 1'b0;
        wait_until(M_GAP, -1);
        check("blank1_score", score, s0);
        wait_until(M_SHOW, 1);
        mole_is_hitted = 1'b1; tick(); mole_is_hitted = 1'b0;
        wait_until(M_GAP, -1);
        check("blank2_score", score, s0);
        wait_until(M_SHOW, 2);
        mole_is_hitted = 1'b1; tick(); mole_is_hitted = 1'b0;
        check("cycle3_pulse", hit_pulse, 1);
        check("cycle3_score", score, s0 + 1);

        // Seventeen timeouts: miss_pulse every time, counter saturates.
        s1 = 0; n = 0;
        while (s1 < 17 && n < 17 * (LIFE + GAP) + 100) begin
            tick(); n++;
            if (miss_pulse) s1++;
        end
        check("miss_pulse_count", s1, 17);
        check("miss_saturated", misses, SMAX);

        // Hit on the last SHOW cycle wins over timeout.
        s0 = m_score;
        wait_until(M_SHOW, LIFE - 1);
        mole_is_hitted = 1'b1; tick(); mole_is_hitted = 1'b0;
        check("last_cycle_hit", hit_pulse, 1);
        check("last_cycle_no_miss", miss_pulse, 0);
        check("last_cycle_score", score, s0 + 1);

        // Stop mid-SHOW, then restart clears the tallies.
        wait_until(M_SHOW, 9);
        s0 = m_score; s1 = m_miss;
        is_started = 1'b0; tick();
        check("stop_hidden", mole_visible, 0);
        check("stop_score_hold", score, s0);
        check("stop_miss_hold", misses, s1);
        tick(); tick(); tick();
        is_started = 1'b1; tick();
        check("restart_score", score, 0);
        check("restart_misses", misses, 0);

`ifdef MOLE_SPEEDUP_EN
        // Three hits shrink the mole lifetime to 14 cycles at LIFE = 20.
        for (int k = 0; k < 3; k++) begin
            wait_until(M_SHOW, 4);
            mole_is_hitted = 1'b1; tick(); mole_is_hitted = 1'b0;
        end
        wait_until(M_SHOW, 0);
        n = 0;
        do begin tick(); n++; end while (!miss_pulse && n < 100);
        check("speedup_life", n, 14);
`endif

        // Randomized play with occasional stops and resets.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 2) == 0) mole_is_hitted = ~mole_is_hitted;
            if ($urandom_range(0, 149) == 0) is_started = ~is_started;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        // Mid-operation reset returns everything to reset values.
        is_started = 1'b1;
        wait_until(M_SHOW, 3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_visible", mole_visible, 0);
        check("midrst_score", score, 0);
        check("midrst_row", mole_row, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
